pipe_chain: RTL

PIPE_CHAIN -- requirements
Module: pipe_chain

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_slot.sv | 50 +++++
 rtl/pipe_chain.sv | 131 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipe_chain register chain.
//   STAGES_MAX    largest legal chain depth
//   FLUSH_CNT_W   width of the saturating flush counter
//   FLUSH_HIT_W   width needed to count flushed slots in one cycle
//   occ_width()   width of an occupancy count for a given depth
//   slot_op_e     per-slot register control (hold / load / clear)
package pipe_pkg;

    localparam int STAGES_MAX  = 16;
    localparam int FLUSH_CNT_W = 16;
    localparam int FLUSH_HIT_W = $clog2(STAGES_MAX + 1);

    function automatic int occ_width(input int stages);
        return $clog2(stages + 1);
    endfunction

    typedef enum logic [1:0] {
        SLOT_HOLD  = 2'd0,
        SLOT_LOAD  = 2'd1,
        SLOT_CLEAR = 2'd2
    } slot_op_e;

endpackage

// File: rtl/pipe_slot.sv
// One register slot of the chain: a valid bit plus payload.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   op           hold, load (valid<=1, data<=load_data) or clear (valid<=0)
//   load_data    payload taken on a load
//   valid, data  registered slot contents
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  slot_op_e          op,
    input  logic [DATA_W-1:0] load_data,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    // A clear leaves the payload untouched; it is meaningless without valid.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        case (op)
            SLOT_LOAD: begin
                valid_d = 1'b1;
                data_d  = load_data;
            end
            SLOT_CLEAR: valid_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/pipe_chain.sv
// Elastic chain of STAGES register slots with bubble collapse, per-slot
// flush, global stall, registered occupancy and a saturating flush counter.
// Ports:
//   clk, rst_n              clock and asynchronous active-low reset
//   in_valid/in_ready/in_data     producer handshake into slot 0
//   out_valid/out_ready/out_data  consumer handshake from slot STAGES-1
//   stall                   freezes every slot; flush_mask ignored
//   flush_mask              bit i drops the entry in slot i at this edge
//   occupancy               registered count of valid slots
//   flush_count             saturating count of entries dropped by flush
module pipe_chain
    import pipe_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int STAGES = 4,
    localparam int OCC_W  = occ_width(STAGES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    input  logic                   stall,
    input  logic [STAGES-1:0]      flush_mask,
    output logic [OCC_W-1:0]       occupancy,
    output logic [FLUSH_CNT_W-1:0] flush_count
);

    logic [STAGES-1:0] slot_valid;
    logic [DATA_W-1:0] slot_data [STAGES];
    slot_op_e          slot_op   [STAGES];

    // free[i]: slot i can take a new entry this edge.
    // move[i]: slot i loads this edge (from slot i-1, or from the input for i=0).
    logic [STAGES-1:0] free;
    logic [STAGES-1:0] move;
    logic [STAGES-1:0] valid_next;
    logic              fire_out;

    logic [OCC_W-1:0]       occ_q, occ_d;
    logic [FLUSH_CNT_W-1:0] flush_count_q, flush_count_d;
    logic [FLUSH_HIT_W-1:0] flush_hits;
    logic [FLUSH_CNT_W:0]   flush_sum;

    // Freedom ripples from the output end back toward the input so that an
    // entry can advance into a slot that is being vacated on the same edge.
    always_comb begin
        free     = '0;
        move     = '0;
        out_valid = slot_valid[STAGES-1] & ~flush_mask[STAGES-1] & ~stall;
        fire_out  = out_valid & out_ready;
        free[STAGES-1] = ~slot_valid[STAGES-1] | flush_mask[STAGES-1] | fire_out;
        for (int i = STAGES - 1; i >= 1; i--) begin
            move[i]   = slot_valid[i-1] & ~flush_mask[i-1] & free[i] & ~stall;
            free[i-1] = ~slot_valid[i-1] | flush_mask[i-1] | move[i];
        end
        in_ready = free[0] & ~stall;
        move[0]  = in_valid & in_ready;
    end

    always_comb begin
        valid_next = slot_valid;
        for (int i = 0; i < STAGES; i++) begin
            slot_op[i] = SLOT_HOLD;
            if (move[i]) begin
                slot_op[i]    = SLOT_LOAD;
                valid_next[i] = 1'b1;
            end else if (!stall && slot_valid[i] && free[i]) begin
                slot_op[i]    = SLOT_CLEAR;
                valid_next[i] = 1'b0;
            end
        end
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_slot
        logic [DATA_W-1:0] load_data;
        if (i == 0) begin : g_head
            assign load_data = in_data;
        end else begin : g_body
            assign load_data = slot_data[i-1];
        end

        pipe_slot #(.DATA_W(DATA_W)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .op        (slot_op[i]),
            .load_data (load_data),
            .valid     (slot_valid[i]),
            .data      (slot_data[i])
        );
    end

    // Occupancy tracks the valid bits as they will be after this edge so the
    // registered count lines up with the slot registers.
    always_comb begin
        occ_d = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ_d = occ_d + OCC_W'(valid_next[i]);
        end
    end

    always_comb begin
        flush_hits = '0;
        if (!stall) begin
            for (int i = 0; i < STAGES; i++) begin
                flush_hits = flush_hits + FLUSH_HIT_W'(slot_valid[i] & flush_mask[i]);
            end
        end
        flush_sum     = {1'b0, flush_count_q} + (FLUSH_CNT_W + 1)'(flush_hits);
        flush_count_d = flush_sum[FLUSH_CNT_W] ? {FLUSH_CNT_W{1'b1}}
                                               : flush_sum[FLUSH_CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q         <= '0;
            flush_count_q <= '0;
        end else begin
            occ_q         <= occ_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign out_data    = slot_data[STAGES-1];
    assign occupancy   = occ_q;
    assign flush_count = flush_count_q;

endmodule
